// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use stalls, MEM-resolved
// redirects and data-memory waits with a watchdog, plus saturating statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_Id,
  input  logic [4:0]  Rt_Id,
  input  logic        Use_Rs_Id,
  input  logic        Use_Rt_Id,
  input  logic [4:0]  Reg_Target_Ex,
  input  logic        MemToReg_Ex,
  input  logic        RegWr_Ex,
  input  logic        Redirect_Mem,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  output logic        PC_Wr,
  output logic        IF_ID_Wr,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Wr,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Wr,
  output logic        EX_MEM_Flush,
  output logic        MEM_WB_Flush,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt,
  output logic        Mem_Timeout
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] LIMIT   = WAIT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_miss;
  logic              load_use;
  logic              freeze;
  logic              redirect_taken;
  logic              timeout_set;

  assign mem_miss = Mem_Req & ~Mem_Ready;
  assign load_use = MemToReg_Ex & RegWr_Ex & (Reg_Target_Ex != 5'd0) &
                    ((Use_Rs_Id & (Rs_Id == Reg_Target_Ex)) |
                     (Use_Rt_Id & (Rt_Id == Reg_Target_Ex)));

  // Next-state and Mealy control outputs
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    freeze         = 1'b0;
    timeout_set    = 1'b0;
    redirect_taken = 1'b0;
    PC_Wr          = 1'b1;
    IF_ID_Wr       = 1'b1;
    IF_ID_Flush    = 1'b0;
    ID_EX_Wr       = 1'b1;
    ID_EX_Flush    = 1'b0;
    EX_MEM_Wr      = 1'b1;
    EX_MEM_Flush   = 1'b0;
    MEM_WB_Flush   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!Mem_Ready) begin
          freeze = 1'b1;
          // Ready arriving in the limit cycle is still a release
          if (wait_q == LIMIT) begin
            state_d     = HALT;
            timeout_set = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      HALT: freeze = 1'b1;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    if (rst) begin
      state_d        = RUN;
      wait_d         = '0;
      timeout_set    = 1'b0;
      PC_Wr          = 1'b0;
      IF_ID_Wr       = 1'b0;
      IF_ID_Flush    = 1'b1;
      ID_EX_Wr       = 1'b0;
      ID_EX_Flush    = 1'b1;
      EX_MEM_Wr      = 1'b0;
      EX_MEM_Flush   = 1'b1;
      MEM_WB_Flush   = 1'b1;
    end else if (freeze) begin
      PC_Wr        = 1'b0;
      IF_ID_Wr     = 1'b0;
      ID_EX_Wr     = 1'b0;
      EX_MEM_Wr    = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (Redirect_Mem) begin
      redirect_taken = 1'b1;
      IF_ID_Flush    = 1'b1;
      ID_EX_Flush    = 1'b1;
      EX_MEM_Flush   = 1'b1;
    end else if (load_use) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // State, wait counter and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      Stall_Cnt   <= '0;
      Flush_Cnt   <= '0;
      Mem_Timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!PC_Wr && (Stall_Cnt != CNT_MAX)) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      if (redirect_taken && (Flush_Cnt != CNT_MAX)) Flush_Cnt <= Flush_Cnt + CNT_W'(1);
      if (timeout_set) Mem_Timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus scored against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LIMIT = 8;

  // Control vector order: PC_Wr IF_ID_Wr IF_ID_Flush ID_EX_Wr ID_EX_Flush EX_MEM_Wr EX_MEM_Flush MEM_WB_Flush
  localparam logic [7:0] C_RESET  = 8'b00101011;
  localparam logic [7:0] C_FREEZE = 8'b00000001;
  localparam logic [7:0] C_REDIR  = 8'b11111110;
  localparam logic [7:0] C_STALL  = 8'b00011100;
  localparam logic [7:0] C_RUN    = 8'b11010100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs_Id = '0, Rt_Id = '0, Reg_Target_Ex = '0;
  logic Use_Rs_Id = 0, Use_Rt_Id = 0, MemToReg_Ex = 0, RegWr_Ex = 0;
  logic Redirect_Mem = 0, Mem_Req = 0, Mem_Ready = 0;
  logic PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, EX_MEM_Flush, MEM_WB_Flush;
  logic [15:0] Stall_Cnt, Flush_Cnt;
  logic Mem_Timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_wait, m_halt, m_to;
  int m_waits, m_stall, m_flush;

  logic [7:0]  obs_ctl, exp_ctl;
  logic [15:0] obs_stall, obs_flush;
  logic        obs_to;
  int          exp_stall, exp_flush;
  bit          exp_to;

  pipe_hazard_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .Rs_Id(Rs_Id), .Rt_Id(Rt_Id),
    .Use_Rs_Id(Use_Rs_Id), .Use_Rt_Id(Use_Rt_Id), .Reg_Target_Ex(Reg_Target_Ex),
    .MemToReg_Ex(MemToReg_Ex), .RegWr_Ex(RegWr_Ex), .Redirect_Mem(Redirect_Mem),
    .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Wr(ID_EX_Wr), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Wr(EX_MEM_Wr), .EX_MEM_Flush(EX_MEM_Flush), .MEM_WB_Flush(MEM_WB_Flush),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Mem_Timeout(Mem_Timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctl_now();
    return {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, EX_MEM_Flush, MEM_WB_Flush};
  endfunction

  // One clock: sample at the falling edge, predict, then advance the model past the rising edge
  task automatic clk_cycle();
    bit miss, lu;
    @(negedge clk);
    obs_ctl   = ctl_now();
    obs_stall = Stall_Cnt;
    obs_flush = Flush_Cnt;
    obs_to    = Mem_Timeout;
    exp_stall = m_stall;
    exp_flush = m_flush;
    exp_to    = m_to;
    lu = MemToReg_Ex && RegWr_Ex && Reg_Target_Ex != 0 &&
         ((Use_Rs_Id && Rs_Id == Reg_Target_Ex) || (Use_Rt_Id && Rt_Id == Reg_Target_Ex));
    if (m_halt)      miss = 1;
    else if (m_wait) miss = !Mem_Ready;
    else             miss = Mem_Req && !Mem_Ready;
    if (rst)               exp_ctl = C_RESET;
    else if (miss)         exp_ctl = C_FREEZE;
    else if (Redirect_Mem) exp_ctl = C_REDIR;
    else if (lu)           exp_ctl = C_STALL;
    else                   exp_ctl = C_RUN;
    if (rst) begin
      m_wait = 0; m_halt = 0; m_to = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (exp_ctl[7] == 1'b0 && m_stall < 65535) m_stall++;
      if (exp_ctl == C_REDIR && m_flush < 65535) m_flush++;
      if (!m_halt) begin
        if (miss && !m_wait) begin
          m_wait = 1; m_waits = 1;
        end else if (miss) begin
          if (m_waits == int'(LIMIT)) begin m_halt = 1; m_to = 1; m_wait = 0; end
          else m_waits++;
        end else if (m_wait) begin
          m_wait = 0; m_waits = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs_Id = 0; Rt_Id = 0; Reg_Target_Ex = 0; Use_Rs_Id = 0; Use_Rt_Id = 0;
    MemToReg_Ex = 0; RegWr_Ex = 0; Redirect_Mem = 0; Mem_Req = 0; Mem_Ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] tgt);
    MemToReg_Ex = 1; RegWr_Ex = 1; Reg_Target_Ex = tgt; Use_Rs_Id = 1; Rs_Id = tgt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    clk_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      checks++;
      if (obs_ctl !== C_RESET) begin
        errors++; $display("FAIL reset_ctl cycle %0d got %b exp %b", i, obs_ctl, C_RESET);
      end
      checks++;
      if (obs_stall !== 16'd0 || obs_flush !== 16'd0 || obs_to !== 1'b0) begin
        errors++; $display("FAIL reset_cnt got stall %0d flush %0d to %b exp 0 0 0", obs_stall, obs_flush, obs_to);
      end
    end
    rst = 0;
    clk_cycle();
    checks++;
    if (obs_ctl !== C_RUN) begin
      errors++; $display("FAIL reset_release got %b exp %b", obs_ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    clk_cycle();
    checks++;
    if (obs_ctl !== C_STALL) begin
      errors++; $display("FAIL load_use_ctl got %b exp %b", obs_ctl, C_STALL);
    end
    idle_inputs();
    clk_cycle();
    checks++;
    if (obs_stall !== 16'd1) begin
      errors++; $display("FAIL load_use_stall_cnt got %0d exp 1", obs_stall);
    end
    set_load_use(5'd0);
    clk_cycle();
    checks++;
    if (obs_ctl !== C_RUN) begin
      errors++; $display("FAIL load_use_r0 got %b exp %b", obs_ctl, C_RUN);
    end
    idle_inputs();
    clk_cycle();
    checks++;
    if (obs_stall !== 16'd1) begin
      errors++; $display("FAIL load_use_r0_cnt got %0d exp 1", obs_stall);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    set_load_use(5'd9);
    Redirect_Mem = 1;
    clk_cycle();
    checks++;
    if (obs_ctl !== C_REDIR) begin
      errors++; $display("FAIL redirect_ctl got %b exp %b", obs_ctl, C_REDIR);
    end
    idle_inputs();
    clk_cycle();
    checks++;
    if (obs_flush !== 16'd1 || obs_stall !== 16'd0) begin
      errors++; $display("FAIL redirect_cnt got flush %0d stall %0d exp 1 0", obs_flush, obs_stall);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    Mem_Req = 1; Mem_Ready = 0; Redirect_Mem = 1;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      checks++;
      if (obs_ctl !== C_FREEZE) begin
        errors++; $display("FAIL mem_wait_freeze cycle %0d got %b exp %b", i, obs_ctl, C_FREEZE);
      end
    end
    Mem_Ready = 1;
    clk_cycle();
    checks++;
    if (obs_ctl !== C_REDIR) begin
      errors++; $display("FAIL mem_wait_release got %b exp %b", obs_ctl, C_REDIR);
    end
    idle_inputs();
    clk_cycle();
    checks++;
    if (obs_stall !== 16'd4 || obs_flush !== 16'd1) begin
      errors++; $display("FAIL mem_wait_cnt got stall %0d flush %0d exp 4 1", obs_stall, obs_flush);
    end
  endtask

  task automatic test_limit_release();
    do_reset();
    Mem_Req = 1; Mem_Ready = 0;
    for (int i = 0; i < int'(LIMIT); i++) clk_cycle();
    Mem_Ready = 1;
    clk_cycle();
    checks++;
    if (obs_ctl !== C_RUN) begin
      errors++; $display("FAIL limit_release_ctl got %b exp %b", obs_ctl, C_RUN);
    end
    idle_inputs();
    clk_cycle();
    checks++;
    if (obs_to !== 1'b0 || obs_ctl !== C_RUN) begin
      errors++; $display("FAIL limit_release_after got to %b ctl %b exp 0 %b", obs_to, obs_ctl, C_RUN);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    Mem_Req = 1; Mem_Ready = 0;
    // One entry cycle in RUN, then LIMIT cycles in MEM_WAIT before the watchdog fires
    for (int i = 0; i < int'(LIMIT) + 1; i++) begin
      clk_cycle();
      checks++;
      if (obs_to !== 1'b0 || obs_ctl !== C_FREEZE) begin
        errors++; $display("FAIL timeout_early cycle %0d got to %b ctl %b exp 0 %b", i, obs_to, obs_ctl, C_FREEZE);
      end
    end
    Mem_Ready = 1; Redirect_Mem = 1;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      checks++;
      if (obs_to !== 1'b1 || obs_ctl !== C_FREEZE) begin
        errors++; $display("FAIL timeout_halt cycle %0d got to %b ctl %b exp 1 %b", i, obs_to, obs_ctl, C_FREEZE);
      end
    end
    rst = 1;
    #1;
    checks++;
    if (Mem_Timeout !== 1'b0 || Stall_Cnt !== 16'd0 || ctl_now() !== C_RESET) begin
      errors++; $display("FAIL timeout_async_rst got to %b stall %0d ctl %b exp 0 0 %b", Mem_Timeout, Stall_Cnt, ctl_now(), C_RESET);
    end
    idle_inputs();
    clk_cycle();
    rst = 0;
    clk_cycle();
    checks++;
    if (obs_ctl !== C_RUN || obs_to !== 1'b0) begin
      errors++; $display("FAIL timeout_recover got ctl %b to %b exp %b 0", obs_ctl, obs_to, C_RUN);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = m_halt && ($urandom_range(0, 3) == 0);
      Rs_Id         = 5'($urandom_range(0, 3));
      Rt_Id         = 5'($urandom_range(0, 3));
      Reg_Target_Ex = 5'($urandom_range(0, 3));
      Use_Rs_Id     = 1'($urandom);
      Use_Rt_Id     = 1'($urandom);
      MemToReg_Ex   = 1'($urandom);
      RegWr_Ex      = ($urandom_range(0, 3) != 0);
      Redirect_Mem  = ($urandom_range(0, 3) == 0);
      Mem_Req       = ($urandom_range(0, 2) == 0);
      Mem_Ready     = ($urandom_range(0, 9) < 6);
      clk_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++; $display("FAIL random_ctl cycle %0d got %b exp %b", i, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_stall !== 16'(exp_stall) || obs_flush !== 16'(exp_flush) || obs_to !== exp_to) begin
        errors++; $display("FAIL random_cnt cycle %0d got %0d %0d %b exp %0d %0d %b",
                           i, obs_stall, obs_flush, obs_to, exp_stall, exp_flush, exp_to);
      end
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(5'd3);
    for (int i = 0; i < 70000; i++) clk_cycle();
    clk_cycle();
    checks++;
    if (obs_stall !== 16'hFFFF || obs_stall !== 16'(exp_stall)) begin
      errors++; $display("FAIL saturation got %h exp ffff (model %h)", obs_stall, 16'(exp_stall));
    end
    clk_cycle();
    checks++;
    if (obs_stall !== 16'hFFFF || obs_ctl !== C_STALL) begin
      errors++; $display("FAIL saturation_hold got %h ctl %b exp ffff %b", obs_stall, obs_ctl, C_STALL);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_limit_release();
    test_timeout();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
